// File: rtl/idp_hazard_ctrl.sv
// Integer-datapath hazard controller: tracks EX/MEM/WB destinations, raises
// load-use / WB-miss stalls and registers the EX-stage forwarding selects.
module idp_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_s_addr,
  input  logic [4:0]       id_t_addr,
  input  logic             id_uses_s,
  input  logic             id_uses_t,
  input  logic [4:0]       id_d_addr,
  input  logic             id_d_en,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwda_sel,
  output logic [1:0]       fwdb_sel,
  output logic             wb_d_en,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       d_en;
    logic       is_load;
    logic [4:0] d_addr;
  } slot_t;

  slot_t            ex_q, mem_q, wb_q, ex_d;
  logic [1:0]       fwda_q, fwdb_q, fwda_d, fwdb_d;
  logic [CNT_W-1:0] cnt_q;
  logic             haz_s, haz_t, go;

  function automatic logic match(input slot_t s, input logic [4:0] a);
    return s.d_en && (s.d_addr == a) && (a != 5'd0);
  endfunction

  // The EX producer reaches MEM alongside the consumer, hence EX_MEM_FWD;
  // a current MEM producer will sit in WB, hence MEM_WB_FWD.
  function automatic logic [1:0] fsel(input logic used, input logic [4:0] a,
                                      input slot_t ex, input slot_t mem);
    if (!used)                          return 2'b00;
    if (match(ex, a) && !ex.is_load)    return 2'b01;
    if (match(mem, a))                  return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    haz_s  = id_uses_s && ((match(ex_q, id_s_addr) && ex_q.is_load) || match(wb_q, id_s_addr));
    haz_t  = id_uses_t && ((match(ex_q, id_t_addr) && ex_q.is_load) || match(wb_q, id_t_addr));
    stall  = id_valid && !flush && (haz_s || haz_t);
    go     = id_valid && !flush && !stall;
    ex_d   = '0;
    fwda_d = 2'b00;
    fwdb_d = 2'b00;
    if (go) begin
      ex_d.d_en    = id_d_en;
      ex_d.is_load = id_is_load;
      ex_d.d_addr  = id_d_addr;
      fwda_d       = fsel(id_uses_s, id_s_addr, ex_q, mem_q);
      fwdb_d       = fsel(id_uses_t, id_t_addr, ex_q, mem_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      fwda_q <= 2'b00;
      fwdb_q <= 2'b00;
      cnt_q  <= '0;
    end else begin
      wb_q   <= mem_q;
      mem_q  <= ex_q;
      ex_q   <= ex_d;
      fwda_q <= fwda_d;
      fwdb_q <= fwdb_d;
      if (stall && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fwda_sel  = fwda_q;
  assign fwdb_sel  = fwdb_q;
  assign wb_d_en   = wb_q.d_en;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_idp_hazard_ctrl.sv
// Scenario bench for idp_hazard_ctrl: expected selects queued at drive time,
// popped and compared one cycle later when the instruction sits in EX.
module tb_idp_hazard_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 0, id_uses_s = 0, id_uses_t = 0, id_d_en = 0, id_is_load = 0, flush = 0;
  logic [4:0] id_s_addr = 0, id_t_addr = 0, id_d_addr = 0;
  logic stall, wb_d_en;
  logic [1:0] fwda_sel, fwdb_sel;
  logic [CNT_W-1:0] stall_cnt, c0;

  typedef struct { logic [1:0] fa; logic [1:0] fb; } exp_t;
  exp_t sbq[$];
  exp_t e;
  int passed = 0, total = 0;

  idp_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_s_addr(id_s_addr), .id_t_addr(id_t_addr),
    .id_uses_s(id_uses_s), .id_uses_t(id_uses_t), .id_d_addr(id_d_addr), .id_d_en(id_d_en),
    .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwda_sel(fwda_sel),
    .fwdb_sel(fwdb_sel), .wb_d_en(wb_d_en), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idset(input logic v, input logic [4:0] s, input logic [4:0] t, input logic us,
                       input logic ut, input logic [4:0] d, input logic de, input logic ld,
                       input logic fl);
    @(negedge clk);
    id_valid = v; id_s_addr = s; id_t_addr = t; id_uses_s = us; id_uses_t = ut;
    id_d_addr = d; id_d_en = de; id_is_load = ld; flush = fl;
    #1;
  endtask

  task automatic tick(input logic [1:0] fa, input logic [1:0] fb);
    exp_t x;
    x.fa = fa; x.fb = fb;
    sbq.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    idset(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    repeat (3) begin idle(); @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else passed++;
    total++; if (fwda_sel !== 2'b00 || fwdb_sel !== 2'b00) $display("FAIL reset_sel got %b/%b want 00/00", fwda_sel, fwdb_sel); else passed++;
    total++; if (wb_d_en !== 1'b0) $display("FAIL reset_wb_d_en got %b want 0", wb_d_en); else passed++;
    total++; if (stall_cnt !== '0) $display("FAIL reset_cnt got %0d want 0", stall_cnt); else passed++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_ex_fwd();
    drain();
    idset(1, 1, 2, 1, 1, 3, 1, 0, 0); tick(2'b00, 2'b00);
    e = sbq.pop_front();
    total++; if (fwda_sel !== e.fa || fwdb_sel !== e.fb) $display("FAIL exfwd_add got %b/%b want %b/%b", fwda_sel, fwdb_sel, e.fa, e.fb); else passed++;
    idset(1, 3, 4, 1, 1, 6, 1, 0, 0);
    total++; if (stall !== 1'b0) $display("FAIL exfwd_stall got %b want 0", stall); else passed++;
    tick(2'b01, 2'b00);
    e = sbq.pop_front();
    total++; if (fwda_sel !== e.fa || fwdb_sel !== e.fb) $display("FAIL exfwd_sub got %b/%b want %b/%b", fwda_sel, fwdb_sel, e.fa, e.fb); else passed++;
  endtask

  task automatic test_mem_fwd();
    drain();
    idset(1, 1, 2, 1, 1, 3, 1, 0, 0); tick(2'b00, 2'b00); void'(sbq.pop_front());
    idle(); tick(2'b00, 2'b00); void'(sbq.pop_front());
    idset(1, 1, 3, 1, 1, 7, 1, 0, 0);
    total++; if (stall !== 1'b0) $display("FAIL memfwd_stall got %b want 0", stall); else passed++;
    tick(2'b00, 2'b10);
    e = sbq.pop_front();
    total++; if (fwda_sel !== e.fa || fwdb_sel !== e.fb) $display("FAIL memfwd_or got %b/%b want %b/%b", fwda_sel, fwdb_sel, e.fa, e.fb); else passed++;
    total++; if (wb_d_en !== 1'b1) $display("FAIL memfwd_wb_d_en got %b want 1", wb_d_en); else passed++;
  endtask

  task automatic test_load_use();
    drain();
    idset(1, 1, 0, 1, 0, 5, 1, 1, 0); tick(2'b00, 2'b00); void'(sbq.pop_front());
    idset(1, 5, 1, 1, 0, 6, 1, 0, 0);
    total++; if (stall !== 1'b1) $display("FAIL lu_stall got %b want 1", stall); else passed++;
    c0 = stall_cnt;
    tick(2'b00, 2'b00);
    e = sbq.pop_front();
    total++; if (fwda_sel !== e.fa || fwdb_sel !== e.fb) $display("FAIL lu_bubble got %b/%b want %b/%b", fwda_sel, fwdb_sel, e.fa, e.fb); else passed++;
    total++; if (stall_cnt !== c0 + 4'd1) $display("FAIL lu_cnt got %0d want %0d", stall_cnt, c0 + 4'd1); else passed++;
    idset(1, 5, 1, 1, 0, 6, 1, 0, 0);
    total++; if (stall !== 1'b0) $display("FAIL lu_release got %b want 0", stall); else passed++;
    tick(2'b10, 2'b00);
    e = sbq.pop_front();
    total++; if (fwda_sel !== e.fa || fwdb_sel !== e.fb) $display("FAIL lu_fwd got %b/%b want %b/%b", fwda_sel, fwdb_sel, e.fa, e.fb); else passed++;
  endtask

  task automatic test_wb_miss();
    drain();
    idset(1, 0, 0, 0, 0, 7, 1, 0, 0); tick(2'b00, 2'b00); void'(sbq.pop_front());
    idle(); tick(2'b00, 2'b00); void'(sbq.pop_front());
    idle(); tick(2'b00, 2'b00); void'(sbq.pop_front());
    idset(1, 1, 7, 0, 1, 8, 1, 0, 0);
    total++; if (stall !== 1'b1) $display("FAIL wbmiss_stall got %b want 1", stall); else passed++;
    tick(2'b00, 2'b00); void'(sbq.pop_front());
    idset(1, 1, 7, 0, 1, 8, 1, 0, 0);
    total++; if (stall !== 1'b0) $display("FAIL wbmiss_release got %b want 0", stall); else passed++;
    tick(2'b00, 2'b00);
    e = sbq.pop_front();
    total++; if (fwda_sel !== e.fa || fwdb_sel !== e.fb) $display("FAIL wbmiss_sel got %b/%b want %b/%b", fwda_sel, fwdb_sel, e.fa, e.fb); else passed++;
  endtask

  task automatic test_reg0_priority();
    drain();
    idset(1, 0, 0, 0, 0, 0, 1, 1, 0); tick(2'b00, 2'b00); void'(sbq.pop_front());
    idset(1, 0, 0, 1, 1, 9, 1, 0, 0);
    total++; if (stall !== 1'b0) $display("FAIL r0_stall got %b want 0", stall); else passed++;
    tick(2'b00, 2'b00);
    e = sbq.pop_front();
    total++; if (fwda_sel !== e.fa || fwdb_sel !== e.fb) $display("FAIL r0_sel got %b/%b want %b/%b", fwda_sel, fwdb_sel, e.fa, e.fb); else passed++;
    idset(1, 0, 0, 0, 0, 4, 1, 0, 0); tick(2'b00, 2'b00); void'(sbq.pop_front());
    idset(1, 0, 0, 0, 0, 4, 1, 0, 0); tick(2'b00, 2'b00); void'(sbq.pop_front());
    idset(1, 4, 4, 1, 1, 10, 1, 0, 0); tick(2'b01, 2'b01);
    e = sbq.pop_front();
    total++; if (fwda_sel !== e.fa || fwdb_sel !== e.fb) $display("FAIL prio_ex_wins got %b/%b want %b/%b", fwda_sel, fwdb_sel, e.fa, e.fb); else passed++;
  endtask

  task automatic test_flush();
    drain();
    idset(1, 0, 0, 0, 0, 8, 1, 1, 0); tick(2'b00, 2'b00); void'(sbq.pop_front());
    idset(1, 8, 0, 1, 0, 9, 1, 0, 1);
    total++; if (stall !== 1'b0) $display("FAIL flush_stall got %b want 0", stall); else passed++;
    c0 = stall_cnt;
    tick(2'b00, 2'b00);
    e = sbq.pop_front();
    total++; if (fwda_sel !== e.fa || fwdb_sel !== e.fb) $display("FAIL flush_sel got %b/%b want %b/%b", fwda_sel, fwdb_sel, e.fa, e.fb); else passed++;
    total++; if (stall_cnt !== c0) $display("FAIL flush_cnt got %0d want %0d", stall_cnt, c0); else passed++;
    idset(1, 9, 0, 1, 0, 11, 1, 0, 0); tick(2'b00, 2'b00);
    e = sbq.pop_front();
    total++; if (fwda_sel !== e.fa || fwdb_sel !== e.fb) $display("FAIL flush_bubble got %b/%b want %b/%b", fwda_sel, fwdb_sel, e.fa, e.fb); else passed++;
  endtask

  task automatic test_reset_mid();
    drain();
    idset(1, 0, 0, 0, 0, 12, 1, 0, 0); tick(2'b00, 2'b00); void'(sbq.pop_front());
    idset(1, 12, 0, 1, 0, 10, 1, 1, 0); tick(2'b01, 2'b00); void'(sbq.pop_front());
    idset(1, 12, 0, 1, 0, 13, 1, 0, 0); tick(2'b10, 2'b00);
    e = sbq.pop_front();
    total++; if (fwda_sel !== e.fa || wb_d_en !== 1'b1) $display("FAIL prerst got sel %b wb %b want %b 1", fwda_sel, wb_d_en, e.fa); else passed++;
    @(negedge clk); rst = 1'b1; #1;
    total++; if (fwda_sel !== 2'b00 || fwdb_sel !== 2'b00) $display("FAIL rstmid_sel got %b/%b want 00/00", fwda_sel, fwdb_sel); else passed++;
    total++; if (wb_d_en !== 1'b0 || stall_cnt !== '0) $display("FAIL rstmid_state got wb %b cnt %0d want 0 0", wb_d_en, stall_cnt); else passed++;
    #2 rst = 1'b0;
    idset(1, 10, 0, 1, 0, 14, 1, 0, 0);
    total++; if (stall !== 1'b0) $display("FAIL rstmid_stall got %b want 0", stall); else passed++;
    tick(2'b00, 2'b00);
    e = sbq.pop_front();
    total++; if (fwda_sel !== e.fa || fwdb_sel !== e.fb) $display("FAIL rstmid_reader got %b/%b want %b/%b", fwda_sel, fwdb_sel, e.fa, e.fb); else passed++;
  endtask

  // A load reading its own destination stalls every other cycle.
  task automatic test_saturate();
    drain();
    repeat (40) begin idset(1, 5, 0, 1, 0, 5, 1, 1, 0); @(posedge clk); #1; end
    total++; if (stall_cnt !== 4'hF) $display("FAIL sat_reach got %0d want 15", stall_cnt); else passed++;
    repeat (4) begin idset(1, 5, 0, 1, 0, 5, 1, 1, 0); @(posedge clk); #1; end
    total++; if (stall_cnt !== 4'hF) $display("FAIL sat_hold got %0d want 15", stall_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_ex_fwd();
    test_mem_fwd();
    test_load_use();
    test_wb_miss();
    test_reg0_priority();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
